// File: rtl/ubc_break_ctrl.sv
// ubc_break_ctrl: user-break matcher that raises IRQ on a bus-cycle match, holds it until acknowledged,
// then ignores matches for HOLDOFF enabled cycles.
module ubc_break_ctrl #(
  parameter int HOLDOFF = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        RES_N,
  input  logic [31:0] BAR,
  input  logic [31:0] BAMR,
  input  logic [15:0] BBR,
  input  logic        MON_VALID,
  input  logic [31:0] MON_A,
  input  logic        MON_CPU,
  input  logic        MON_IF,
  input  logic        MON_WE,
  input  logic [1:0]  MON_SZ,
  input  logic        INT_ACK,
  output logic        IRQ,
  output logic [31:0] BRK_ADDR,
  output logic        BRK_FLAG,
  input  logic        FLAG_CLR
);
  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] cd, id, rw, sz;
  logic ena, addr_hit, cyc_hit, sz_hit, match, take;
  logic unused_bbr;
  assign {cd, id, rw, sz} = BBR[7:0];
  assign unused_bbr = ^BBR[15:8];
  assign ena      = |cd & |id & |rw;
  assign addr_hit = ((MON_A ^ BAR) & ~BAMR) == 32'd0;
  assign cyc_hit  = cd[~MON_CPU] & id[~MON_IF] & rw[MON_WE];
  // SZ codes 01/10/11 select byte/word/long, i.e. one above the MON_SZ encoding
  assign sz_hit   = (sz == 2'b00) | ({1'b0, sz} == {1'b0, MON_SZ} + 3'd1);
  assign match    = MON_VALID & ena & addr_hit & cyc_hit & sz_hit;
  assign take     = (state == IDLE) & match;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (CE_R) begin
      state <= RES_N ? state_nx : IDLE;
      cnt   <= RES_N ? cnt_nx : '0;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: state_nx = match ? PEND : IDLE;
      PEND: begin
        state_nx = INT_ACK ? HOLD : (ena ? PEND : IDLE);
        cnt_nx   = INT_ACK ? 8'(HOLDOFF - 1) : cnt;
      end
      HOLD: begin
        state_nx = (cnt == 8'd0) ? IDLE : HOLD;
        cnt_nx   = (cnt == 8'd0) ? cnt : cnt - 8'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign IRQ = (state == PEND);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BRK_ADDR <= '0;
      BRK_FLAG <= 1'b0;
    end else if (CE_R) begin
      BRK_ADDR <= !RES_N ? 32'd0 : (take ? MON_A : BRK_ADDR);
      BRK_FLAG <= RES_N & (take | (BRK_FLAG & ~FLAG_CLR));
    end
  end
endmodule

// File: tb/tb_ubc_break_ctrl.sv
// tb_ubc_break_ctrl: directed stimulus with an edge-counting behavioural model checked every cycle.
module tb_ubc_break_ctrl;
  localparam int HO = 8;
  logic        CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b1, RES_N = 1'b1;
  logic [31:0] BAR = '0, BAMR = '0, MON_A = '0;
  logic [15:0] BBR = '0;
  logic        MON_VALID = 1'b0, MON_CPU = 1'b0, MON_IF = 1'b0, MON_WE = 1'b0;
  logic [1:0]  MON_SZ = '0;
  logic        INT_ACK = 1'b0, FLAG_CLR = 1'b0;
  logic        IRQ, BRK_FLAG;
  logic [31:0] BRK_ADDR;
  int n_tests = 0, n_fail = 0;

  ubc_break_ctrl #(.HOLDOFF(HO)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .RES_N(RES_N),
    .BAR(BAR), .BAMR(BAMR), .BBR(BBR),
    .MON_VALID(MON_VALID), .MON_A(MON_A), .MON_CPU(MON_CPU), .MON_IF(MON_IF),
    .MON_WE(MON_WE), .MON_SZ(MON_SZ), .INT_ACK(INT_ACK),
    .IRQ(IRQ), .BRK_ADDR(BRK_ADDR), .BRK_FLAG(BRK_FLAG), .FLAG_CLR(FLAG_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit spec_en(input logic [15:0] b);
    return b[7:6] != 2'b00 && b[5:4] != 2'b00 && b[3:2] != 2'b00;
  endfunction

  function automatic bit spec_match();
    bit cyc;
    int s, ms;
    cyc = (MON_CPU ? BBR[6] : BBR[7]) && (MON_IF ? BBR[4] : BBR[5]) && (MON_WE ? BBR[3] : BBR[2]);
    s = int'(BBR[1:0]);
    ms = int'(MON_SZ);
    return MON_VALID && spec_en(BBR) && (((MON_A ^ BAR) & ~BAMR) == 32'd0) && cyc && (s == 0 || s == ms + 1);
  endfunction

  // Model: a break is pending or not; matches are refused until HO edges after the acknowledging edge.
  bit          m_pend, m_flag, m_set;
  logic [31:0] m_addr;
  int          k, ack_k;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N || (CE_R && !RES_N)) begin
      m_pend = 0; m_flag = 0; m_addr = '0; k = 0; ack_k = -1000;
    end else if (CE_R) begin
      k++;
      m_set = !m_pend && spec_match() && k > ack_k + HO;
      if (m_pend) begin
        if (INT_ACK) begin m_pend = 0; ack_k = k; end
        else if (!spec_en(BBR)) m_pend = 0;
      end else if (m_set) begin
        m_pend = 1; m_addr = MON_A;
      end
      m_flag = m_set ? 1'b1 : (FLAG_CLR ? 1'b0 : m_flag);
    end
  end

  always @(posedge CLK) begin
    #3;
    chk("model_irq", IRQ, m_pend);
    chk("model_addr", BRK_ADDR, m_addr);
    chk("model_flag", BRK_FLAG, m_flag);
  end

  task automatic bus(input logic v, input logic [31:0] a, input logic cpu, input logic ifc,
                     input logic we, input logic [1:0] sz);
    MON_VALID = v; MON_A = a; MON_CPU = cpu; MON_IF = ifc; MON_WE = we; MON_SZ = sz;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic ack_and_wait();
    INT_ACK = 1'b1; idle(1); INT_ACK = 1'b0;
    idle(HO + 2);
  endtask

  int got;
  initial begin
    @(negedge CLK); @(negedge CLK);
    chk("reset_irq", IRQ, 0);
    chk("reset_addr", BRK_ADDR, 0);
    chk("reset_flag", BRK_FLAG, 0);
    RST_N = 1'b1;
    // basic break: long CPU read
    BAR = 32'h1000; BAMR = 0; BBR = 16'h00FF;
    bus(1, 32'h1000, 1, 0, 0, 2'b10);
    chk("basic_irq", IRQ, 1);
    chk("basic_addr", BRK_ADDR, 32'h1000);
    chk("basic_flag", BRK_FLAG, 1);
    ack_and_wait();
    // mask and size: long-only, low nibble masked
    BAMR = 32'hF;
    bus(1, 32'h100C, 1, 0, 0, 2'b01);
    chk("size_word_irq", IRQ, 0);
    bus(1, 32'h100C, 1, 0, 0, 2'b10);
    chk("size_long_irq", IRQ, 1);
    chk("mask_addr", BRK_ADDR, 32'h100C);
    ack_and_wait();
    // condition filter: CPU, fetch, read, byte
    BAMR = 0; BAR = 32'h2000; BBR = 16'h0055;
    bus(1, 32'h2000, 0, 1, 0, 2'b00);
    chk("cond_dma_irq", IRQ, 0);
    bus(1, 32'h2000, 1, 0, 0, 2'b00);
    chk("cond_data_irq", IRQ, 0);
    bus(1, 32'h2000, 1, 1, 1, 2'b00);
    chk("cond_write_irq", IRQ, 0);
    bus(1, 32'h2000, 1, 1, 0, 2'b00);
    chk("cond_fetch_irq", IRQ, 1);
    chk("cond_addr", BRK_ADDR, 32'h2000);
    ack_and_wait();
    // hold-off: matches every edge, re-break only at ack+HO+1
    BBR = 16'h00FF; BAR = 32'h3000;
    bus(1, 32'h3000, 1, 0, 0, 2'b10);
    chk("ho_first_irq", IRQ, 1);
    INT_ACK = 1'b1; bus(1, 32'h3000, 1, 0, 0, 2'b10); INT_ACK = 1'b0;
    chk("ho_ack_irq", IRQ, 0);
    got = 0;
    for (int i = 1; i <= 20 && got == 0; i++) begin
      bus(1, 32'h3000, 1, 0, 0, 2'b10);
      if (IRQ) got = i;
    end
    chk("ho_rebreak_edge", got, HO + 1);
    // CE_R low freezes everything, including a pending ack
    CE_R = 1'b0; INT_ACK = 1'b1;
    idle(3);
    chk("freeze_irq", IRQ, 1);
    CE_R = 1'b1; INT_ACK = 1'b0;
    // disable while pending
    BBR = 16'h0000;
    idle(1);
    chk("dis_irq", IRQ, 0);
    chk("dis_flag", BRK_FLAG, 1);
    BBR = 16'h00FF;
    idle(1);
    chk("dis_flag_sticky", BRK_FLAG, 1);
    FLAG_CLR = 1'b1; idle(1); FLAG_CLR = 1'b0;
    chk("flag_clr", BRK_FLAG, 0);
    FLAG_CLR = 1'b1; bus(1, 32'h3000, 1, 0, 0, 2'b10); FLAG_CLR = 1'b0;
    chk("flag_set_wins", BRK_FLAG, 1);
    chk("flag_set_irq", IRQ, 1);
    // soft reset in PEND
    RES_N = 1'b0; bus(1, 32'h3000, 1, 0, 0, 2'b10); RES_N = 1'b1;
    chk("resn_irq", IRQ, 0);
    chk("resn_addr", BRK_ADDR, 0);
    chk("resn_flag", BRK_FLAG, 0);
    bus(1, 32'h3000, 1, 0, 0, 2'b10);
    chk("resn_rebreak", IRQ, 1);
    // async reset in HOLD
    INT_ACK = 1'b1; idle(1); INT_ACK = 1'b0;
    idle(1);
    #2 RST_N = 1'b0;
    #1;
    chk("rstn_irq", IRQ, 0);
    chk("rstn_addr", BRK_ADDR, 0);
    chk("rstn_flag", BRK_FLAG, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    bus(1, 32'h3000, 1, 0, 0, 2'b10);
    chk("rstn_rebreak", IRQ, 1);
    chk("rstn_rebreak_addr", BRK_ADDR, 32'h3000);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
